// File: rtl/ahblite_master_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : ahblite_master_arbiter
// Brief    : Two-master (Cortex-M0 core / DMA) AHB-Lite arbiter. Bus ownership
//            changes only on transfer boundaries, so fixed-length bursts are
//            never split. Define ARB_FAIRNESS_EN to add a DMA hold-limit.
// Revision : 1.0 - initial release
//==============================================================================
module ahblite_master_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADY,
    input  logic [1:0] HTRANSC,
    input  logic [2:0] HBURSTC,
    input  logic [1:0] HTRANSD,
    input  logic [2:0] HBURSTD,
    input  logic       DMAREQ,
    output logic       DMAGNT,
    output logic       HMASTERSEL,
    output logic       HDATASEL,
    output logic       HSTALLC
);

    localparam logic [1:0] c_IDLE    = 2'b00;
    localparam logic [1:0] c_NONSEQ  = 2'b10;
    localparam logic [1:0] c_SEQ     = 2'b11;

    localparam logic [0:0] c_ST_CORE = 1'b0;
    localparam logic [0:0] c_ST_DMA  = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [4:0] r_beat;
    logic [4:0] w_beat_nxt;
    logic [4:0] w_burst_last;
    logic [1:0] w_own_trans;
    logic [2:0] w_own_burst;
    logic       w_bound;
    logic       w_fair_hit;
    logic       r_datasel;

    // The address-phase owner's transfer drives the beat counter.
    assign w_own_trans = (r_state == c_ST_DMA) ? HTRANSD : HTRANSC;
    assign w_own_burst = (r_state == c_ST_DMA) ? HBURSTD : HBURSTC;

    always_comb begin
        case (w_own_burst[2:1])
            2'b00:   w_burst_last = 5'd0;
            2'b01:   w_burst_last = 5'd3;
            2'b10:   w_burst_last = 5'd7;
            default: w_burst_last = 5'd15;
        endcase
    end

    always_comb begin
        w_beat_nxt = r_beat;
        if (HREADY) begin
            if (w_own_trans == c_NONSEQ) begin
                w_beat_nxt = w_burst_last;
            end else if (w_own_trans == c_SEQ && r_beat != 5'd0) begin
                w_beat_nxt = r_beat - 5'd1;
            end
        end
    end

    // Boundary: the transfer accepted this cycle is the last of its burst.
    assign w_bound = HREADY && (w_beat_nxt == 5'd0);

`ifdef ARB_FAIRNESS_EN
    localparam logic [HOLD_W-1:0] c_MAX_HOLD = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_dma_beat;

    assign w_dma_beat = (r_state == c_ST_DMA) && HREADY && HTRANSD[1];

    // Saturates so a DMA that never reaches a boundary cannot wrap the count.
    always_comb begin
        w_hold_nxt = r_hold;
        if (w_dma_beat && HTRANSC != c_IDLE && r_hold != {HOLD_W{1'b1}}) begin
            w_hold_nxt = r_hold + 1'b1;
        end
    end

    assign w_fair_hit = (w_hold_nxt >= c_MAX_HOLD);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_hold <= '0;
        end else if (r_state == c_ST_CORE && w_state_nxt == c_ST_DMA) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_hold_nxt;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{MAX_HOLD, HOLD_W};
    assign w_fair_hit   = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state   <= c_ST_CORE;
            r_beat    <= 5'd0;
            r_datasel <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (HREADY) begin
                r_datasel <= HMASTERSEL;
            end
        end
    end

    // The core must be idle when handing over so no core address is dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_CORE: begin
                if (DMAREQ && HTRANSC == c_IDLE && w_bound) begin
                    w_state_nxt = c_ST_DMA;
                end
            end
            c_ST_DMA: begin
                if (w_bound && (!DMAREQ || w_fair_hit)) begin
                    w_state_nxt = c_ST_CORE;
                end
            end
        endcase
    end

    always_comb begin
        HMASTERSEL = 1'b1;
        DMAGNT     = 1'b0;
        if (r_state == c_ST_DMA) begin
            HMASTERSEL = 1'b0;
            DMAGNT     = 1'b1;
        end
    end

    assign HDATASEL = r_datasel;
    assign HSTALLC  = DMAGNT;

endmodule
`default_nettype wire

// File: tb/tb_ahblite_master_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_ahblite_master_arbiter
// Brief    : Directed scenarios plus randomized traffic checked against a
//            transaction-level ownership model. Honours ARB_FAIRNESS_EN.
// Revision : 1.0 - initial release
//==============================================================================
module tb_ahblite_master_arbiter;

    localparam int MH = 4;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic       HREADY = 1'b1;
    logic [1:0] HTRANSC = 2'b00;
    logic [2:0] HBURSTC = 3'd0;
    logic [1:0] HTRANSD = 2'b00;
    logic [2:0] HBURSTD = 3'd0;
    logic       DMAREQ = 1'b0;
    logic       DMAGNT;
    logic       HMASTERSEL;
    logic       HDATASEL;
    logic       HSTALLC;

    int checks   = 0;
    int failures = 0;

    // Ownership model: who owns the address phase, beats left in the burst.
    bit m_core    = 1'b1;
    bit m_datasel = 1'b1;
    int m_left    = 0;
    int m_hold    = 0;

    ahblite_master_arbiter #(
        .MAX_HOLD(MH),
        .HOLD_W  (5)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HREADY    (HREADY),
        .HTRANSC   (HTRANSC),
        .HBURSTC   (HBURSTC),
        .HTRANSD   (HTRANSD),
        .HBURSTD   (HBURSTD),
        .DMAREQ    (DMAREQ),
        .DMAGNT    (DMAGNT),
        .HMASTERSEL(HMASTERSEL),
        .HDATASEL  (HDATASEL),
        .HSTALLC   (HSTALLC)
    );

    always #5 HCLK = ~HCLK;

    function automatic int burst_beats(input logic [2:0] hb);
        case (hb)
            3'd0, 3'd1: return 1;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    task automatic model_step();
        logic [1:0] tr;
        int         left;
        bit         was_core;
        bit         fair;
        if (HRESET) begin
            m_core    = 1'b1;
            m_datasel = 1'b1;
            m_left    = 0;
            m_hold    = 0;
        end else if (HREADY) begin
            was_core = m_core;
            tr   = m_core ? HTRANSC : HTRANSD;
            left = m_left;
            if (tr == 2'b10) left = burst_beats(m_core ? HBURSTC : HBURSTD) - 1;
            else if (tr == 2'b11 && left > 0) left = left - 1;
            if (FAIR && !m_core && HTRANSD inside {2'b10, 2'b11} && HTRANSC != 2'b00)
                m_hold = m_hold + 1;
            fair = FAIR && (m_hold >= MH);
            if (m_core && DMAREQ && HTRANSC == 2'b00 && left == 0) begin
                m_core = 1'b0;
                m_hold = 0;
            end else if (!m_core && left == 0 && (!DMAREQ || fair)) begin
                m_core = 1'b1;
            end
            m_left    = left;
            m_datasel = was_core;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_bus();
        HRESET  = 1'b0;
        HREADY  = 1'b1;
        HTRANSC = 2'b00;
        HBURSTC = 3'd0;
        HTRANSD = 2'b00;
        HBURSTD = 3'd0;
    endtask

    task automatic test_reset();
        idle_bus();
        HRESET = 1'b1;
        DMAREQ = 1'b0;
        tick();
        tick();
        checks++; if (HMASTERSEL !== 1'b1) begin failures++; $display("FAIL reset_mastersel got=%0b exp=1", HMASTERSEL); end
        checks++; if (HDATASEL !== 1'b1) begin failures++; $display("FAIL reset_datasel got=%0b exp=1", HDATASEL); end
        checks++; if (DMAGNT !== 1'b0) begin failures++; $display("FAIL reset_dmagnt got=%0b exp=0", DMAGNT); end
        checks++; if (HSTALLC !== 1'b0) begin failures++; $display("FAIL reset_stallc got=%0b exp=0", HSTALLC); end
        HRESET = 1'b0;
    endtask

    task automatic test_grant_latency();
        idle_bus();
        DMAREQ = 1'b0;
        tick();
        DMAREQ = 1'b1;
        tick();
        checks++; if (HMASTERSEL !== 1'b0) begin failures++; $display("FAIL grant_mastersel got=%0b exp=0", HMASTERSEL); end
        checks++; if (DMAGNT !== 1'b1) begin failures++; $display("FAIL grant_dmagnt got=%0b exp=1", DMAGNT); end
        checks++; if (HSTALLC !== 1'b1) begin failures++; $display("FAIL grant_stallc got=%0b exp=1", HSTALLC); end
        checks++; if (HDATASEL !== 1'b1) begin failures++; $display("FAIL grant_datasel_early got=%0b exp=1", HDATASEL); end
        tick();
        checks++; if (HDATASEL !== 1'b0) begin failures++; $display("FAIL grant_datasel got=%0b exp=0", HDATASEL); end
        DMAREQ = 1'b0;
        tick();
        checks++; if (HMASTERSEL !== 1'b1) begin failures++; $display("FAIL release_mastersel got=%0b exp=1", HMASTERSEL); end
        tick();
        checks++; if (HDATASEL !== 1'b1) begin failures++; $display("FAIL release_datasel got=%0b exp=1", HDATASEL); end
    endtask

    task automatic test_burst_no_split();
        idle_bus();
        DMAREQ = 1'b1;
        tick();
        HTRANSD = 2'b10;
        HBURSTD = 3'd5;
        tick();
        HTRANSD = 2'b11;
        tick();
        DMAREQ = 1'b0;
        checks++; if (HMASTERSEL !== 1'b0) begin failures++; $display("FAIL burst_beat2_mastersel got=%0b exp=0", HMASTERSEL); end
        for (int b = 3; b <= 8; b++) begin
            if (b == 5) begin
                HREADY = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    checks++; if (DMAGNT !== 1'b1) begin failures++; $display("FAIL burst_wait_dmagnt k=%0d got=%0b exp=1", k, DMAGNT); end
                end
                HREADY = 1'b1;
            end
            tick();
            checks++; if (HMASTERSEL !== (b == 8)) begin failures++; $display("FAIL burst_beat_mastersel beat=%0d got=%0b exp=%0b", b, HMASTERSEL, b == 8); end
        end
        checks++; if (HDATASEL !== 1'b0) begin failures++; $display("FAIL burst_last_datasel got=%0b exp=0", HDATASEL); end
        HTRANSD = 2'b00;
        tick();
        checks++; if (HDATASEL !== 1'b1) begin failures++; $display("FAIL burst_after_datasel got=%0b exp=1", HDATASEL); end
    endtask

    task automatic test_core_priority();
        idle_bus();
        HTRANSC = 2'b10;
        HBURSTC = 3'd0;
        DMAREQ  = 1'b1;
        tick();
        checks++; if (HMASTERSEL !== 1'b1) begin failures++; $display("FAIL prio_nosw_mastersel got=%0b exp=1", HMASTERSEL); end
        HTRANSC = 2'b00;
        HREADY  = 1'b0;
        tick();
        checks++; if (DMAGNT !== 1'b0) begin failures++; $display("FAIL prio_wait_dmagnt got=%0b exp=0", DMAGNT); end
        HREADY = 1'b1;
        tick();
        checks++; if (DMAGNT !== 1'b1) begin failures++; $display("FAIL prio_grant_dmagnt got=%0b exp=1", DMAGNT); end
        DMAREQ = 1'b0;
        tick();
        checks++; if (HMASTERSEL !== 1'b1) begin failures++; $display("FAIL prio_release_mastersel got=%0b exp=1", HMASTERSEL); end
    endtask

    task automatic test_fairness();
        idle_bus();
        DMAREQ = 1'b1;
        tick();
        HTRANSC = 2'b10;
        HBURSTC = 3'd0;
        HTRANSD = 2'b10;
        HBURSTD = 3'd0;
`ifdef ARB_FAIRNESS_EN
        for (int b = 1; b <= MH; b++) begin
            tick();
            checks++; if (HSTALLC !== (b < MH)) begin failures++; $display("FAIL fair_stallc beat=%0d got=%0b exp=%0b", b, HSTALLC, b < MH); end
        end
        HTRANSD = 2'b00;
        tick();
        checks++; if (HMASTERSEL !== 1'b1) begin failures++; $display("FAIL fair_core_mastersel got=%0b exp=1", HMASTERSEL); end
        HTRANSC = 2'b00;
        tick();
        checks++; if (DMAGNT !== 1'b1) begin failures++; $display("FAIL fair_regrant_dmagnt got=%0b exp=1", DMAGNT); end
`else
        for (int b = 1; b <= MH + 2; b++) begin
            tick();
            checks++; if (HSTALLC !== 1'b1) begin failures++; $display("FAIL hold_stallc beat=%0d got=%0b exp=1", b, HSTALLC); end
        end
`endif
        HTRANSD = 2'b00;
        DMAREQ  = 1'b0;
        tick();
        checks++; if (HMASTERSEL !== 1'b1) begin failures++; $display("FAIL fair_release_mastersel got=%0b exp=1", HMASTERSEL); end
        HTRANSC = 2'b00;
        tick();
    endtask

    task automatic test_reset_midburst();
        idle_bus();
        DMAREQ = 1'b1;
        tick();
        HTRANSD = 2'b10;
        HBURSTD = 3'd3;
        tick();
        HTRANSD = 2'b11;
        tick();
        HRESET = 1'b1;
        tick();
        checks++; if (HMASTERSEL !== 1'b1) begin failures++; $display("FAIL rstmid_mastersel got=%0b exp=1", HMASTERSEL); end
        checks++; if (DMAGNT !== 1'b0) begin failures++; $display("FAIL rstmid_dmagnt got=%0b exp=0", DMAGNT); end
        checks++; if (HDATASEL !== 1'b1) begin failures++; $display("FAIL rstmid_datasel got=%0b exp=1", HDATASEL); end
        // A cleared beat counter lets an idle core hand over immediately.
        idle_bus();
        tick();
        checks++; if (DMAGNT !== 1'b1) begin failures++; $display("FAIL rstmid_cnt_clear_dmagnt got=%0b exp=1", DMAGNT); end
        DMAREQ = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            HRESET  = ($urandom_range(0, 199) == 0);
            HREADY  = ($urandom_range(0, 3) != 0);
            HTRANSC = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(0, 3));
            HBURSTC = 3'($urandom_range(0, 7));
            HTRANSD = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 4) HTRANSD = 2'b11;
            HBURSTD = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) DMAREQ = ~DMAREQ;
            tick();
            checks++; if (HMASTERSEL !== m_core) begin failures++; $display("FAIL rand_mastersel cyc=%0d got=%0b exp=%0b", cyc, HMASTERSEL, m_core); end
            checks++; if (DMAGNT !== !m_core) begin failures++; $display("FAIL rand_dmagnt cyc=%0d got=%0b exp=%0b", cyc, DMAGNT, !m_core); end
            checks++; if (HSTALLC !== !m_core) begin failures++; $display("FAIL rand_stallc cyc=%0d got=%0b exp=%0b", cyc, HSTALLC, !m_core); end
            checks++; if (HDATASEL !== m_datasel) begin failures++; $display("FAIL rand_datasel cyc=%0d got=%0b exp=%0b", cyc, HDATASEL, m_datasel); end
        end
    endtask

    initial begin
        test_reset();
        test_grant_latency();
        test_burst_no_split();
        test_core_priority();
        test_fairness();
        test_reset_midburst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
